// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) sequencer: shifts out opcode and 24-bit address, then streams
// received bytes through a one-byte valid/ready buffer, stalling SCK when the buffer is full.
module spi_flash_reader #(
    parameter int          CLKDIV   = 2,
    parameter logic [7:0]  CMD_READ = 8'h03,
    parameter int          CS_GAP   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    logic [2:0]  state_q,    state_d;
    logic [15:0] div_cnt_q,  div_cnt_d;
    logic [4:0]  bit_cnt_q,  bit_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] gap_cnt_q,  gap_cnt_d;
    logic [31:0] tx_sr_q,    tx_sr_d;
    logic [7:0]  rx_sr_q,    rx_sr_d;
    logic [7:0]  rd_data_q,  rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        sck_q,      sck_d;
    logic        mosi_q,     mosi_d;
    logic        cs_n_q,     cs_n_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        aborted_q,  aborted_d;

    logic phase_end;
    logic shifting;

    assign phase_end = (div_cnt_q == DIV_LAST);
    assign shifting  = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = aborted_q;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (busy_q) begin
                    // Second cycle of a zero-length request.
                    busy_d = 1'b0;
                end else if (start && !abort) begin
                    busy_d = 1'b1;
                    if (len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_CMD;
                        cs_n_d     = 1'b0;
                        sck_d      = 1'b0;
                        mosi_d     = CMD_READ[7];
                        tx_sr_d    = {CMD_READ[6:0], addr, 1'b0};
                        div_cnt_d  = 16'd0;
                        bit_cnt_d  = 5'd0;
                        byte_cnt_d = len;
                        aborted_d  = 1'b0;
                    end
                end
            end

            ST_CMD, ST_ADDR, ST_DATA: begin
                if (!phase_end) begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end else begin
                    div_cnt_d = 16'd0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], spi_miso};
                    end else begin
                        sck_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (state_q == ST_CMD) begin
                            mosi_d  = tx_sr_q[31];
                            tx_sr_d = {tx_sr_q[30:0], 1'b0};
                            if (bit_cnt_q == 5'd7) begin
                                state_d = ST_ADDR;
                            end
                        end else if (state_q == ST_ADDR) begin
                            if (bit_cnt_q == 5'd31) begin
                                state_d   = ST_DATA;
                                bit_cnt_d = 5'd0;
                                mosi_d    = 1'b0;
                            end else begin
                                mosi_d  = tx_sr_q[31];
                                tx_sr_d = {tx_sr_q[30:0], 1'b0};
                            end
                        end else if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = 5'd0;
                            byte_cnt_d = byte_cnt_q - 16'd1;
                            if (!rd_valid_q || rd_ready) begin
                                rd_data_d  = rx_sr_q;
                                rd_valid_d = 1'b1;
                                if (byte_cnt_q == 16'd1) begin
                                    state_d   = ST_GAP;
                                    cs_n_d    = 1'b1;
                                    gap_cnt_d = 16'd0;
                                end
                            end else begin
                                // Buffer still full: park with SCK low, keep the byte in rx_sr.
                                state_d = ST_HOLD;
                            end
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (rd_ready) begin
                    rd_data_d  = rx_sr_q;
                    rd_valid_d = 1'b1;
                    div_cnt_d  = 16'd0;
                    if (byte_cnt_q == 16'd0) begin
                        state_d   = ST_GAP;
                        cs_n_d    = 1'b1;
                        gap_cnt_d = 16'd0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_GAP: begin
                if ((gap_cnt_q >= GAP_LAST) && !rd_valid_d) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = !aborted_q;
                end else if (gap_cnt_q < GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_GAP;
            cs_n_d     = 1'b1;
            sck_d      = 1'b0;
            mosi_d     = 1'b0;
            rd_valid_d = 1'b0;
            gap_cnt_d  = 16'd0;
            aborted_d  = 1'b1;
            done_d     = 1'b0;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= 16'd0;
            bit_cnt_q  <= 5'd0;
            byte_cnt_q <= 16'd0;
            gap_cnt_q  <= 16'd0;
            tx_sr_q    <= 32'd0;
            rx_sr_q    <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

    // Both shifting and non-shifting states share the same output flops.
    logic unused_ok;
    assign unused_ok = shifting;

endmodule
